note_recorder: RTL and testbench

NOTE_RECORDER -- requirements
Module: note_recorder

---
 rtl/note_recorder.sv | 230 +++++++++++++++++++++++
 tb/tb_note_recorder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// Multi-key note recorder: captures press/release pairs as {key, start, duration}
// events in a small memory and replays them against a tick-based time base.
module note_recorder #(
  parameter int NUM_KEYS = 4,
  parameter int TICK_DIV = 500000,
  parameter int TIME_W   = 13,
  parameter int DEPTH    = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_KEYS-1:0]      keys_n,
  input  logic                     record_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [NUM_KEYS-1:0]      key_out,
  output logic [1:0]               mode,
  output logic [TIME_W-1:0]        sys_time,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow
);

  localparam int KW    = $clog2(NUM_KEYS);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = KW + 2 * TIME_W;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_FLUSH  = 2'b11,
    S_PLAY   = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [TIME_W-1:0]       time_q, time_d;
  logic [NUM_KEYS-1:0]     keys_q;
  logic [NUM_KEYS-1:0]     active_q, active_d;
  logic [NUM_KEYS-1:0]     pend_q, pend_d;
  logic [TIME_W-1:0]       start_q [NUM_KEYS];
  logic [TIME_W-1:0]       start_d [NUM_KEYS];
  logic [TIME_W-1:0]       pend_start_q [NUM_KEYS];
  logic [TIME_W-1:0]       pend_start_d [NUM_KEYS];
  logic [TIME_W-1:0]       pend_dur_q [NUM_KEYS];
  logic [TIME_W-1:0]       pend_dur_d [NUM_KEYS];
  logic [TIME_W-1:0]       off_q [NUM_KEYS];
  logic [TIME_W-1:0]       off_d [NUM_KEYS];
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic                    ovf_q, ovf_d;
  logic                    wait_q, wait_d;
  logic [NUM_KEYS-1:0]     key_out_q, key_out_d;

  logic [EW-1:0]           mem [DEPTH];
  logic [EW-1:0]           rd_data_q;
  logic                    wr_en;
  logic [KW-1:0]           wr_key;
  logic [EW-1:0]           wr_data;
  logic [KW-1:0]           rd_key;
  logic [TIME_W-1:0]       rd_start, rd_dur;

  assign rd_key   = rd_data_q[EW-1 -: KW];
  assign rd_start = rd_data_q[2*TIME_W-1 -: TIME_W];
  assign rd_dur   = rd_data_q[TIME_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    state_d      = state_q;
    div_d        = div_q;
    time_d       = time_q;
    active_d     = active_q;
    pend_d       = pend_q;
    start_d      = start_q;
    pend_start_d = pend_start_q;
    pend_dur_d   = pend_dur_q;
    off_d        = off_q;
    count_d      = count_q;
    issued_d     = issued_q;
    ovf_d        = ovf_q;
    wait_d       = wait_q;
    key_out_d    = key_out_q;
    wr_en        = 1'b0;

    wr_key = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_q[k]) wr_key = KW'(k);
    end
    wr_data = {wr_key, pend_start_q[wr_key], pend_dur_q[wr_key]};

    if (state_q != S_IDLE) begin
      if (div_q == '0) begin
        div_d  = DIV_MAX;
        time_d = time_q + 1'b1;
      end else begin
        div_d = div_q - 1'b1;
      end
    end

    // Writer runs ahead of release capture so a same-cycle release re-arms pend.
    if ((state_q == S_RECORD || state_q == S_FLUSH) && pend_q != '0) begin
      pend_d[wr_key] = 1'b0;
      if (count_q == CW'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (record_start) begin
          state_d  = S_RECORD;
          count_d  = '0;
          ovf_d    = 1'b0;
          div_d    = DIV_MAX;
          time_d   = '0;
          active_d = '0;
          pend_d   = '0;
        end else if (play_start && count_q != '0) begin
          state_d   = S_PLAY;
          div_d     = DIV_MAX;
          time_d    = '0;
          issued_d  = '0;
          wait_d    = 1'b1;
          key_out_d = '0;
        end
      end
      S_RECORD: begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (!keys_q[k] && keys_n[k] && active_q[k]) begin
            active_d[k]     = 1'b0;
            pend_d[k]       = 1'b1;
            pend_start_d[k] = start_q[k];
            pend_dur_d[k]   = time_q - start_q[k];
          end else if (keys_q[k] && !keys_n[k] && !stop) begin
            active_d[k] = 1'b1;
            start_d[k]  = time_q;
          end
        end
        // A release landing on the stop cycle is a complete note and is kept.
        if (stop) begin
          active_d = '0;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pend_q == '0) state_d = S_IDLE;
      end
      S_PLAY: begin
        if (stop) begin
          key_out_d = '0;
          state_d   = S_IDLE;
        end else begin
          for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_out_q[k] && time_q == off_q[k]) key_out_d[k] = 1'b0;
          end
          if (wait_q) begin
            wait_d = 1'b0;
          end else if (issued_q != count_q && time_q >= rd_start) begin
            issued_d = issued_q + 1'b1;
            wait_d   = 1'b1;
            if (rd_dur != '0) begin
              key_out_d[rd_key] = 1'b1;
              off_d[rd_key]     = time_q + rd_dur;
            end
          end
          if (issued_q == count_q && key_out_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= DIV_MAX;
      time_q    <= '0;
      keys_q    <= '1;
      active_q  <= '0;
      pend_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      ovf_q     <= 1'b0;
      wait_q    <= 1'b0;
      key_out_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        start_q[k]      <= '0;
        pend_start_q[k] <= '0;
        pend_dur_q[k]   <= '0;
        off_q[k]        <= '0;
      end
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      time_q       <= time_d;
      keys_q       <= keys_n;
      active_q     <= active_d;
      pend_q       <= pend_d;
      start_q      <= start_d;
      pend_start_q <= pend_start_d;
      pend_dur_q   <= pend_dur_d;
      off_q        <= off_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
      ovf_q        <= ovf_d;
      wait_q       <= wait_d;
      key_out_q    <= key_out_d;
    end
  end

  // NOTE: the event memory has no reset; its contents only matter below count_q.
  always_ff @(posedge clock) begin
    if (wr_en) mem[count_q[AW-1:0]] <= wr_data;
    rd_data_q <= mem[issued_q[AW-1:0]];
  end

  assign key_out     = key_out_q;
  assign mode        = state_q;
  assign sys_time    = time_q;
  assign event_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: every change of {mode, key_out, event_count,
// overflow} is matched against a queue of hand-computed expected states.
module tb_note_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  keys_n = 4'b1111;
  logic        record_start = 1'b0;
  logic        play_start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  key_out;
  logic [1:0]  mode;
  logic [12:0] sys_time;
  logic [2:0]  event_count;
  logic        overflow;

  note_recorder #(
    .NUM_KEYS(4), .TICK_DIV(4), .TIME_W(13), .DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .keys_n(keys_n),
    .record_start(record_start), .play_start(play_start), .stop(stop),
    .key_out(key_out), .mode(mode), .sys_time(sys_time),
    .event_count(event_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [9:0]  st;
    bit          chk_t;
    logic [12:0] t;
  } sb_t;

  sb_t        sb_q[$];
  bit         mon_en = 1'b0;
  logic [9:0] mon_prev;
  logic [9:0] mon_cur;
  sb_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] m, input logic [3:0] k, input logic [2:0] c,
                      input logic o, input bit ct, input int t);
    sb_t e;
    e.st    = {m, k, c, o};
    e.chk_t = ct;
    e.t     = 13'(t);
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_cur = {mode, key_out, event_count, overflow};
      if (mon_cur != mon_prev) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got state %h with nothing expected", mon_cur);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_state", 32'(mon_cur), 32'(mon_e.st));
          if (mon_e.chk_t) check("sb_time", 32'(sys_time), 32'(mon_e.t));
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic do_record();
    @(posedge clock); #1 record_start = 1'b1;
    @(posedge clock); #1 record_start = 1'b0;
  endtask

  task automatic do_play();
    @(posedge clock); #1 play_start = 1'b1;
    @(posedge clock); #1 play_start = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clock); #1 stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
  endtask

  // Returns just after the edge on which sys_time first shows t.
  task automatic wait_time(input int t);
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (sys_time != 13'(t) && n < 400);
    if (sys_time != 13'(t)) begin
      n_total++;
      $display("FAIL wait_time: sys_time %0d, wanted %0d", sys_time, t);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (mode != 2'b00 && n < 2000);
    if (mode != 2'b00) begin
      n_total++;
      $display("FAIL wait_idle: mode %b after %0d cycles", mode, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_mode", 32'(mode), 0);
    check("rst_key_out", 32'(key_out), 0);
    check("rst_sys_time", 32'(sys_time), 0);
    check("rst_event_count", 32'(event_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    mon_prev = 10'd0;
    mon_en = 1'b1;

    // Single note: key 2, ticks 3..10, then replay.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b11, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b00, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b10, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b10, 4'b0100, 3'd1, 1'b0, 1, 3);
    push(2'b10, 4'b0000, 3'd1, 1'b0, 1, 10);
    push(2'b00, 4'b0000, 3'd1, 1'b0, 0, 0);
    do_record();
    wait_time(3);  keys_n[2] = 1'b0;
    wait_time(10); keys_n[2] = 1'b1;
    repeat (4) @(posedge clock);
    do_stop();
    repeat (3) @(posedge clock);
    do_play();
    wait_idle();
    repeat (5) @(posedge clock);
    do_stop();
    repeat (2) @(posedge clock);
    #1;
    check("idle_hold_time", 32'(sys_time), 10);
    check("idle_stop_mode", 32'(mode), 0);

    // Simultaneous release of keys 0 and 3: key 0 stored first.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b11, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b00, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b10, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b10, 4'b0001, 3'd2, 1'b0, 1, 1);
    push(2'b10, 4'b1001, 3'd2, 1'b0, 1, 2);
    push(2'b10, 4'b0000, 3'd2, 1'b0, 1, 4);
    push(2'b00, 4'b0000, 3'd2, 1'b0, 0, 0);
    do_record();
    wait_time(1); keys_n[0] = 1'b0;
    wait_time(2); keys_n[3] = 1'b0;
    wait_time(4); keys_n = 4'b1111;
    repeat (4) @(posedge clock);
    do_stop();
    repeat (3) @(posedge clock);
    do_play();
    wait_idle();

    // Six notes into a four-entry memory.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd3, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd4, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd4, 1'b1, 0, 0);
    push(2'b11, 4'b0000, 3'd4, 1'b1, 0, 0);
    push(2'b00, 4'b0000, 3'd4, 1'b1, 0, 0);
    do_record();
    wait_time(1); keys_n = 4'b0000;
    wait_time(2); keys_n = 4'b1111;
    wait_time(3); keys_n = 4'b1100;
    wait_time(4); keys_n = 4'b1111;
    repeat (4) @(posedge clock);
    do_stop();
    repeat (3) @(posedge clock);
    #1;
    check("ovf_count", 32'(event_count), 4);
    check("ovf_flag", 32'(overflow), 1);

    // Stop with key 1 held and key 0 released on the stop cycle.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b11, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b11, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b00, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b10, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b10, 4'b0001, 3'd1, 1'b0, 1, 1);
    push(2'b10, 4'b0000, 3'd1, 1'b0, 1, 2);
    push(2'b00, 4'b0000, 3'd1, 1'b0, 0, 0);
    do_record();
    wait_time(1); keys_n = 4'b1100;
    wait_time(2); keys_n[0] = 1'b1; stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
    repeat (4) @(posedge clock);
    keys_n[1] = 1'b1;
    repeat (3) @(posedge clock);
    do_play();
    wait_idle();

    // play_start ignored in RECORD; stop mid-PLAY with key_out = 0101.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b11, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b00, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b10, 4'b0000, 3'd2, 1'b0, 0, 0);
    push(2'b10, 4'b0001, 3'd2, 1'b0, 1, 1);
    push(2'b10, 4'b0101, 3'd2, 1'b0, 1, 1);
    push(2'b00, 4'b0000, 3'd2, 1'b0, 1, 3);
    do_record();
    do_play();
    wait_time(1); keys_n = 4'b1010;
    wait_time(5); keys_n = 4'b1111;
    repeat (4) @(posedge clock);
    do_stop();
    repeat (3) @(posedge clock);
    do_play();
    wait_time(3);
    stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
    check("play_stop_key_out", 32'(key_out), 0);
    check("play_stop_mode", 32'(mode), 0);

    // Asynchronous reset mid-RECORD.
    push(2'b01, 4'b0000, 3'd0, 1'b0, 0, 0);
    push(2'b01, 4'b0000, 3'd1, 1'b0, 0, 0);
    push(2'b00, 4'b0000, 3'd0, 1'b0, 0, 0);
    do_record();
    wait_time(1); keys_n[3] = 1'b0;
    wait_time(2); keys_n[3] = 1'b1; keys_n[1] = 1'b0;
    wait_time(3);
    #2 reset = 1'b1;
    #1;
    check("arst_mode", 32'(mode), 0);
    check("arst_sys_time", 32'(sys_time), 0);
    check("arst_event_count", 32'(event_count), 0);
    check("arst_key_out", 32'(key_out), 0);
    check("arst_overflow", 32'(overflow), 0);
    keys_n = 4'b1111;
    @(posedge clock); #1 reset = 1'b0;
    do_play();
    repeat (3) @(posedge clock);
    #1;
    check("arst_play_mode", 32'(mode), 0);
    check("arst_play_count", 32'(event_count), 0);

    repeat (5) @(posedge clock);
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
